// File: rtl/mem_bus_bridge.sv
// Bridge from the multicycle controller memory port to a single-outstanding
// request/response system bus, with registered outputs and a response timeout.
module mem_bus_bridge #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        BusErr,
  output logic        BusReq,
  output logic        BusWe,
  output logic [31:0] BusAddr,
  output logic [31:0] BusWData,
  input  logic        BusGnt,
  input  logic        BusRValid,
  input  logic [31:0] BusRData
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              busreq_q, busreq_d;
  logic              buswe_q, buswe_d;
  logic [31:0]       busaddr_q, busaddr_d;
  logic [31:0]       buswdata_q, buswdata_d;

  assign ReadData = rdata_q;
  assign MemReady = ready_q;
  assign BusErr   = err_q;
  assign BusReq   = busreq_q;
  assign BusWe    = buswe_q;
  assign BusAddr  = busaddr_q;
  assign BusWData = buswdata_q;

  // State and output registers, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rdata_q    <= 32'h0000_0000;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      busreq_q   <= 1'b0;
      buswe_q    <= 1'b0;
      busaddr_q  <= 32'h0000_0000;
      buswdata_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      busreq_q   <= busreq_d;
      buswe_q    <= buswe_d;
      busaddr_q  <= busaddr_d;
      buswdata_q <= buswdata_d;
    end
  end

  // Next-state logic; MemReady/BusErr are computed one cycle early so they
  // are high exactly while the machine sits in DONE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    busreq_d   = busreq_q;
    buswe_d    = buswe_q;
    busaddr_d  = busaddr_q;
    buswdata_d = buswdata_q;
    case (state_q)
      ST_IDLE: begin
        if (MemReq) begin
          busaddr_d  = {Adr[31:2], 2'b00};
          buswe_d    = MemWrite;
          buswdata_d = WriteData;
          busreq_d   = 1'b1;
          state_d    = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (BusGnt) begin
          busreq_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_WAIT;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (BusRValid) begin
          if (!buswe_q) begin
            rdata_d = BusRData;
          end else begin
            rdata_d = rdata_q;
          end
          ready_d = 1'b1;
          state_d = ST_DONE;
        end else if (cnt_q == TO_LAST) begin
          ready_d = 1'b1;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed bench for mem_bus_bridge: a transaction-level model predicts every
// output each cycle, and hand-computed literals pin the key scenarios.
module tb_mem_bus_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemReq = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Adr = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic [31:0] ReadData;
  logic        MemReady;
  logic        BusErr;
  logic        BusReq;
  logic        BusWe;
  logic [31:0] BusAddr;
  logic [31:0] BusWData;
  logic        BusGnt = 1'b0;
  logic        BusRValid = 1'b0;
  logic [31:0] BusRData = 32'h0;

  mem_bus_bridge #(.TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .MemReq(MemReq), .MemWrite(MemWrite),
    .Adr(Adr), .WriteData(WriteData), .ReadData(ReadData),
    .MemReady(MemReady), .BusErr(BusErr), .BusReq(BusReq), .BusWe(BusWe),
    .BusAddr(BusAddr), .BusWData(BusWData), .BusGnt(BusGnt),
    .BusRValid(BusRValid), .BusRData(BusRData)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int rst_cnt = 0;
  int grants = 0;

  logic [31:0] exp_rdata = 32'h0, exp_addr = 32'h0, exp_wdata = 32'h0;
  logic        exp_ready = 1'b0, exp_err = 1'b0, exp_busreq = 1'b0, exp_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge reset) rst_cnt++;

  initial forever begin
    @(posedge clk);
    if (BusReq && BusGnt) grants++;
  end

  task automatic m_zero();
    exp_rdata = 32'h0; exp_addr = 32'h0; exp_wdata = 32'h0;
    exp_ready = 1'b0; exp_err = 1'b0; exp_busreq = 1'b0; exp_we = 1'b0;
  endtask

  // One whole transaction, starting from the edge that sampled MemReq.
  task automatic model_txn(input int seen);
    int  n;
    bit  timed_out;
    logic we;
    we = MemWrite;
    exp_we = MemWrite;
    exp_addr = {Adr[31:2], 2'b00};
    exp_wdata = WriteData;
    exp_busreq = 1'b1;
    forever begin
      @(posedge clk);
      if (rst_cnt != seen) begin m_zero(); return; end
      if (BusGnt) break;
    end
    exp_busreq = 1'b0;
    n = 0;
    timed_out = 1'b0;
    forever begin
      @(posedge clk);
      if (rst_cnt != seen) begin m_zero(); return; end
      if (BusRValid) begin
        if (!we) exp_rdata = BusRData;
        break;
      end
      n++;
      if (n == TO) begin timed_out = 1'b1; break; end
    end
    exp_ready = 1'b1;
    exp_err = timed_out;
    @(posedge clk);
    if (rst_cnt != seen) begin m_zero(); return; end
    exp_ready = 1'b0;
    exp_err = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    if (!reset) m_zero();
    else if (MemReq) model_txn(rst_cnt);
  end

  initial forever begin
    @(posedge clk);
    #2;
    chk("ReadData", ReadData, exp_rdata);
    chk("MemReady", {31'h0, MemReady}, {31'h0, exp_ready});
    chk("BusErr", {31'h0, BusErr}, {31'h0, exp_err});
    chk("BusReq", {31'h0, BusReq}, {31'h0, exp_busreq});
    chk("BusWe", {31'h0, BusWe}, {31'h0, exp_we});
    chk("BusAddr", BusAddr, exp_addr);
    chk("BusWData", BusWData, exp_wdata);
  end

  task automatic nx();
    @(negedge clk);
  endtask

  int g0;

  initial begin
    nx(); nx();
    chk("rst_ReadData", ReadData, 32'h0);
    chk("rst_BusReq", {31'h0, BusReq}, 32'h0);
    chk("rst_MemReady", {31'h0, MemReady}, 32'h0);
    reset = 1'b1;
    nx();

    // single read, best-case latency
    MemReq = 1'b1; MemWrite = 1'b0; Adr = 32'h0000_1007;
    nx(); BusGnt = 1'b1;
    chk("rd_BusReq", {31'h0, BusReq}, 32'h1);
    chk("rd_BusAddr", BusAddr, 32'h0000_1004);
    nx(); BusGnt = 1'b0; BusRValid = 1'b1; BusRData = 32'hE3A0_0005;
    nx(); BusRValid = 1'b0;
    chk("rd_MemReady", {31'h0, MemReady}, 32'h1);
    chk("rd_ReadData", ReadData, 32'hE3A0_0005);
    chk("rd_BusErr", {31'h0, BusErr}, 32'h0);
    MemReq = 1'b0;
    nx(); nx();

    // single write with grant delayed three cycles; inputs disturbed after latch
    MemReq = 1'b1; MemWrite = 1'b1; Adr = 32'h0000_0020; WriteData = 32'hCAFE_F00D;
    for (int i = 1; i <= 4; i++) begin
      nx();
      if (i == 1) begin Adr = 32'hFFFF_FFF0; WriteData = 32'h0; MemWrite = 1'b0; end
      chk("wr_BusReq", {31'h0, BusReq}, 32'h1);
      chk("wr_BusWData", BusWData, 32'hCAFE_F00D);
      chk("wr_BusAddr", BusAddr, 32'h0000_0020);
      BusGnt = (i == 4);
    end
    nx(); BusGnt = 1'b0; BusRValid = 1'b1; BusRData = 32'hDEAD_BEEF;
    chk("wr_BusReq_off", {31'h0, BusReq}, 32'h0);
    nx(); BusRValid = 1'b0;
    chk("wr_MemReady", {31'h0, MemReady}, 32'h1);
    chk("wr_ReadData", ReadData, 32'hE3A0_0005);
    MemReq = 1'b0;
    nx(); nx();

    // timeout: no response after grant
    MemReq = 1'b1; MemWrite = 1'b0; Adr = 32'h0000_0040;
    nx(); BusGnt = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      nx(); BusGnt = 1'b0;
      chk("to_early", {31'h0, MemReady}, 32'h0);
    end
    nx();
    chk("to_MemReady", {31'h0, MemReady}, 32'h1);
    chk("to_BusErr", {31'h0, BusErr}, 32'h1);
    chk("to_ReadData", ReadData, 32'hE3A0_0005);
    MemReq = 1'b0;
    nx(); BusRValid = 1'b1; BusRData = 32'h0000_1234;
    chk("to_err_pulse", {31'h0, BusErr}, 32'h0);
    nx(); BusRValid = 1'b0;
    chk("late_ReadData", ReadData, 32'hE3A0_0005);
    chk("late_MemReady", {31'h0, MemReady}, 32'h0);
    nx();

    // back-to-back read then write, MemReq held through DONE
    g0 = grants;
    MemReq = 1'b1; MemWrite = 1'b0; Adr = 32'h0000_0100;
    nx(); BusGnt = 1'b1;
    nx(); BusGnt = 1'b0; BusRValid = 1'b1; BusRData = 32'h1111_2222;
    nx(); BusRValid = 1'b0;
    chk("b2b_rd_ready", {31'h0, MemReady}, 32'h1);
    MemWrite = 1'b1; Adr = 32'h0000_0104; WriteData = 32'h55AA_55AA;
    nx();
    chk("b2b_idle_req", {31'h0, BusReq}, 32'h0);
    chk("b2b_idle_rdy", {31'h0, MemReady}, 32'h0);
    nx(); BusGnt = 1'b1;
    chk("b2b_wr_req", {31'h0, BusReq}, 32'h1);
    chk("b2b_wr_addr", BusAddr, 32'h0000_0104);
    chk("b2b_wr_we", {31'h0, BusWe}, 32'h1);
    nx(); BusGnt = 1'b0; BusRValid = 1'b1; BusRData = 32'h0;
    nx(); BusRValid = 1'b0;
    chk("b2b_wr_ready", {31'h0, MemReady}, 32'h1);
    chk("b2b_ReadData", ReadData, 32'h1111_2222);
    MemReq = 1'b0;
    nx();
    chk("b2b_grants", grants - g0, 32'd2);

    // asynchronous reset while waiting for a response
    MemReq = 1'b1; MemWrite = 1'b0; Adr = 32'h0000_0200;
    nx(); BusGnt = 1'b1;
    nx(); BusGnt = 1'b0;
    nx();
    #2 reset = 1'b0;
    #1;
    chk("ar_ReadData", ReadData, 32'h0);
    chk("ar_BusAddr", BusAddr, 32'h0);
    chk("ar_BusWData", BusWData, 32'h0);
    chk("ar_BusReq", {31'h0, BusReq}, 32'h0);
    chk("ar_MemReady", {31'h0, MemReady}, 32'h0);
    MemReq = 1'b0;
    nx(); nx(); reset = 1'b1;
    nx();
    MemReq = 1'b1; Adr = 32'h0000_0300;
    nx(); BusGnt = 1'b1;
    nx(); BusGnt = 1'b0; BusRValid = 1'b1; BusRData = 32'h0BAD_F00D;
    nx(); BusRValid = 1'b0;
    chk("ar2_MemReady", {31'h0, MemReady}, 32'h1);
    chk("ar2_ReadData", ReadData, 32'h0BAD_F00D);
    MemReq = 1'b0;
    nx();

    // spurious response in IDLE
    BusRValid = 1'b1; BusRData = 32'hFFFF_FFFF;
    nx(); BusRValid = 1'b0;
    chk("sp_MemReady", {31'h0, MemReady}, 32'h0);
    chk("sp_ReadData", ReadData, 32'h0BAD_F00D);
    nx(); nx();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
